pwm_drive: RTL and testbench

Signed-duty PWM generator directly downstream of `pid`: it consumes the PID control output `co_o` and drives one H-bridge channel with a PWM line and a direction line. The duty is latched only at period boundaries, and a one-cycle `upd_o` pulse marks each boundary so the PID loop can run one iteration per PWM period. Optional dead time masks the PWM output after a direction reversal.

---
 rtl/pwm_drive.sv | 181 ++++++++++++++++++
 tb/tb_pwm_drive.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_drive.sv
// Signed-duty PWM driver for one H-bridge channel; duty is latched once per period.
// Build option: define PWM_DEADTIME_EN to mask pwm_o for `dead` cycles after a reversal.
`ifndef PID_RES
`define PID_RES 16
`endif

module pwm_drive #(
  parameter int nbits = `PID_RES,
  parameter int presc = 4,
  parameter int dead  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [nbits-1:0] duty_i,
  output logic                    pwm_o,
  output logic                    dir_o,
  output logic                    upd_o,
  output logic                    sat_o
);

  localparam int CW = nbits - 1;
  localparam int PW = (presc > 1) ? $clog2(presc) : 1;
  localparam logic [CW-1:0]           TOP      = {CW{1'b1}};
  localparam logic [CW-1:0]           CNT_LAST = TOP - CW'(1);
  localparam logic [PW-1:0]           PRE_LAST = PW'(presc - 1);
  localparam logic signed [nbits-1:0] DUTY_MIN = {1'b1, {CW{1'b0}}};

  // state | meaning
  // IDLE  | counters parked at 0, pwm low, dir held
  // RUN   | counting, pwm = cnt < mag
  // DEAD  | counting, pwm forced low after a reversal (PWM_DEADTIME_EN only)
`ifdef PWM_DEADTIME_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;
  localparam logic [7:0] DEAD_LOAD = 8'(dead - 1);
`else
  typedef enum logic {S_IDLE, S_RUN} state_t;
`endif

  state_t                    state_q, state_d;
  logic [PW-1:0]             pre_q, pre_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic signed [nbits-1:0]   duty_q, duty_d;
  logic [CW-1:0]             mag_q, mag_d;
  logic                      dir_q, dir_d;
  logic                      upd_q, upd_d;
  logic                      pwm_q, pwm_d;
  logic                      wrap;
  logic                      latch;
  logic                      new_dir;
`ifdef PWM_DEADTIME_EN
  logic [7:0]                dead_q, dead_d;
`else
  logic                      unused_dead;
  assign unused_dead = (dead == 0);
`endif

  // The most negative duty has no positive counterpart; clip it to full scale.
  function automatic logic [CW-1:0] mag_of(input logic signed [nbits-1:0] d);
    if (d == DUTY_MIN) return TOP;
    return d[nbits-1] ? CW'(-d) : CW'(d);
  endfunction

  assign wrap = (pre_q == PRE_LAST) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    mag_d   = mag_q;
    dir_d   = dir_q;
    upd_d   = 1'b0;
    pwm_d   = 1'b0;
    latch   = 1'b0;
    new_dir = dir_q;
`ifdef PWM_DEADTIME_EN
    dead_d  = dead_q;
`endif
    if (duty_i[nbits-1]) begin
      new_dir = 1'b1;
    end else if (duty_i != '0) begin
      new_dir = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        pre_d = '0;
        cnt_d = '0;
        if (en) begin
          state_d = S_RUN;
          latch   = 1'b1;
        end
      end
      default: begin
        if (!en) begin
          state_d = S_IDLE;
          pre_d   = '0;
          cnt_d   = '0;
        end else begin
          if (pre_q == PRE_LAST) begin
            pre_d = '0;
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
          end else begin
            pre_d = pre_q + PW'(1);
          end
          pwm_d = (state_q == S_RUN) && (cnt_q < mag_q);
          latch = wrap;
`ifdef PWM_DEADTIME_EN
          if (state_q == S_DEAD) begin
            if (dead_q == 8'd0) state_d = S_RUN;
            else                dead_d  = dead_q - 8'd1;
          end
          // A reversal also restarts the mask when one is already running.
          if (wrap && (new_dir != dir_q) && (mag_of(duty_i) != '0)) begin
            state_d = S_DEAD;
            dead_d  = DEAD_LOAD;
          end
`endif
        end
      end
    endcase

    if (latch) begin
      duty_d = duty_i;
      mag_d  = mag_of(duty_i);
      dir_d  = new_dir;
      upd_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      mag_q   <= '0;
      dir_q   <= 1'b0;
      upd_q   <= 1'b0;
      pwm_q   <= 1'b0;
    end else if (clr) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      mag_q   <= '0;
      dir_q   <= 1'b0;
      upd_q   <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      mag_q   <= mag_d;
      dir_q   <= dir_d;
      upd_q   <= upd_d;
      pwm_q   <= pwm_d;
    end
  end

`ifdef PWM_DEADTIME_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dead_q <= '0;
    end else if (clr) begin
      dead_q <= '0;
    end else begin
      dead_q <= dead_d;
    end
  end
`endif

  assign pwm_o = pwm_q;
  assign dir_o = dir_q;
  assign upd_o = upd_q;
  assign sat_o = (duty_q == DUTY_MIN);

endmodule

// File: tb/tb_pwm_drive.sv
// Directed bench for pwm_drive: nbits = 8, presc = 1 (DUT A) and presc = 4 (DUT B).
`timescale 1ns/1ps
module tb_pwm_drive;
`ifdef PWM_DEADTIME_EN
  localparam int DM = 16;
`else
  localparam int DM = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a, clr_a, en_a, pwm_a, dir_a, upd_a, sat_a;
  logic signed [7:0] duty_a;
  logic              rst_b, clr_b, en_b, pwm_b, dir_b, upd_b, sat_b;
  logic signed [7:0] duty_b;

  int n_chk = 0;
  int n_fail = 0;

  pwm_drive #(.nbits(8), .presc(1), .dead(16)) u_dut_a (
    .clk(clk), .rst(rst_a), .clr(clr_a), .en(en_a), .duty_i(duty_a),
    .pwm_o(pwm_a), .dir_o(dir_a), .upd_o(upd_a), .sat_o(sat_a));

  pwm_drive #(.nbits(8), .presc(4), .dead(16)) u_dut_b (
    .clk(clk), .rst(rst_b), .clr(clr_b), .en(en_b), .duty_i(duty_b),
    .pwm_o(pwm_b), .dir_o(dir_b), .upd_o(upd_b), .sat_o(sat_b));

  task automatic wait_upd_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (upd_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_a(input int n, output int highs, output int nupd, output int last_upd,
                         output int first_hi, output int last_hi);
    highs = 0; nupd = 0; last_upd = -1; first_hi = -1; last_hi = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (pwm_a) begin
        highs++;
        if (first_hi < 0) first_hi = k;
        last_hi = k;
      end
      if (upd_a) begin
        nupd++;
        last_upd = k;
      end
    end
  endtask

  task automatic test_reset();
    rst_a = 0; clr_a = 0; en_a = 0; duty_a = 0;
    rst_b = 0; clr_b = 0; en_b = 0; duty_b = 0;
    #12;
    n_chk++; if ({pwm_a, dir_a, upd_a, sat_a} !== 4'b0) begin n_fail++; $display("FAIL reset_a: got %b, expected 0000", {pwm_a, dir_a, upd_a, sat_a}); end
    n_chk++; if ({pwm_b, dir_b, upd_b, sat_b} !== 4'b0) begin n_fail++; $display("FAIL reset_b: got %b, expected 0000", {pwm_b, dir_b, upd_b, sat_b}); end
    @(negedge clk);
    rst_a = 1; rst_b = 1;
    repeat (3) @(negedge clk);
    n_chk++; if ({pwm_a, upd_a} !== 2'b00) begin n_fail++; $display("FAIL idle_a: got %b, expected 00", {pwm_a, upd_a}); end
  endtask

  task automatic test_pos64();
    int hi, nu, lu, fh, lh;
    duty_a = 8'sd64; en_a = 1;
    @(negedge clk);
    n_chk++; if (upd_a !== 1'b1) begin n_fail++; $display("FAIL en_upd: got %b, expected 1", upd_a); end
    n_chk++; if ({dir_a, sat_a} !== 2'b00) begin n_fail++; $display("FAIL pos_dir_sat: got %b, expected 00", {dir_a, sat_a}); end
    count_a(127, hi, nu, lu, fh, lh);
    n_chk++; if (hi != 64) begin n_fail++; $display("FAIL pos64_highs: got %0d, expected 64", hi); end
    n_chk++; if (nu != 1 || lu != 127) begin n_fail++; $display("FAIL pos64_upd: got n=%0d at %0d, expected n=1 at 127", nu, lu); end
    n_chk++; if (fh != 1 || lh != 64) begin n_fail++; $display("FAIL pos64_window: got %0d..%0d, expected 1..64", fh, lh); end
    count_a(127, hi, nu, lu, fh, lh);
    n_chk++; if (hi != 64 || lu != 127) begin n_fail++; $display("FAIL pos64_p2: got highs=%0d upd_at=%0d, expected 64/127", hi, lu); end
  endtask

  task automatic test_midchange();
    bit ok;
    int hi, nu, lu, fh, lh;
    duty_a = 8'sd32;
    wait_upd_a(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL mid_upd_timeout: got none, expected upd_o"); end
    hi = 0;
    for (int k = 1; k <= 127; k++) begin
      @(negedge clk);
      if (pwm_a) hi++;
      if (k == 50) duty_a = 8'sd96;
    end
    n_chk++; if (hi != 32) begin n_fail++; $display("FAIL mid_keep32: got %0d, expected 32", hi); end
    n_chk++; if (upd_a !== 1'b1) begin n_fail++; $display("FAIL mid_upd: got %b, expected 1", upd_a); end
    count_a(127, hi, nu, lu, fh, lh);
    n_chk++; if (hi != 96) begin n_fail++; $display("FAIL mid_new96: got %0d, expected 96", hi); end
  endtask

  task automatic test_sat();
    bit ok;
    int hi, nu, lu, fh, lh;
    duty_a = -8'sd128;
    wait_upd_a(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL sat_upd_timeout: got none, expected upd_o"); end
    n_chk++; if ({dir_a, sat_a} !== 2'b11) begin n_fail++; $display("FAIL sat_set: got dir,sat=%b, expected 11", {dir_a, sat_a}); end
    duty_a = -8'sd127;
    count_a(127, hi, nu, lu, fh, lh);
    n_chk++; if (hi != 127 - DM) begin n_fail++; $display("FAIL sat_highs: got %0d, expected %0d", hi, 127 - DM); end
    n_chk++; if ({dir_a, sat_a} !== 2'b10 || lu != 127) begin n_fail++; $display("FAIL sat_clear: got dir,sat=%b upd_at=%0d, expected 10/127", {dir_a, sat_a}, lu); end
    count_a(127, hi, nu, lu, fh, lh);
    n_chk++; if (hi != 127) begin n_fail++; $display("FAIL full127_highs: got %0d, expected 127", hi); end
  endtask

  task automatic test_reversal();
    bit ok;
    int hi, nu, lu, fh, lh;
    duty_a = 8'sd50;
    wait_upd_a(ok);
    n_chk++; if (!ok || dir_a !== 1'b0) begin n_fail++; $display("FAIL rev_pos: got ok=%0d dir=%b, expected 1/0", ok, dir_a); end
    duty_a = -8'sd50;
    wait_upd_a(ok);
    n_chk++; if (!ok || dir_a !== 1'b1) begin n_fail++; $display("FAIL rev_neg: got ok=%0d dir=%b, expected 1/1", ok, dir_a); end
    count_a(127, hi, nu, lu, fh, lh);
    n_chk++; if (fh != DM + 1) begin n_fail++; $display("FAIL rev_gap: got first high %0d, expected %0d", fh, DM + 1); end
    n_chk++; if (hi != 50 - DM || lh != 50) begin n_fail++; $display("FAIL rev_highs: got %0d last %0d, expected %0d last 50", hi, lh, 50 - DM); end
  endtask

  task automatic test_en_drop();
    int hi, nu, lu, fh, lh;
    repeat (30) @(negedge clk);
    n_chk++; if (pwm_a !== 1'b1) begin n_fail++; $display("FAIL drop_pre: got %b, expected 1", pwm_a); end
    en_a = 0;
    @(negedge clk);
    n_chk++; if ({pwm_a, dir_a, upd_a} !== 3'b010) begin n_fail++; $display("FAIL drop_next: got pwm,dir,upd=%b, expected 010", {pwm_a, dir_a, upd_a}); end
    count_a(200, hi, nu, lu, fh, lh);
    n_chk++; if (hi != 0 || nu != 0) begin n_fail++; $display("FAIL drop_idle: got highs=%0d upd=%0d, expected 0/0", hi, nu); end
    duty_a = 8'sd0; en_a = 1;
    @(negedge clk);
    n_chk++; if ({upd_a, dir_a} !== 2'b11) begin n_fail++; $display("FAIL zero_reen: got upd,dir=%b, expected 11", {upd_a, dir_a}); end
    count_a(127, hi, nu, lu, fh, lh);
    n_chk++; if (hi != 0 || dir_a !== 1'b1 || lu != 127) begin n_fail++; $display("FAIL zero_run: got highs=%0d dir=%b upd_at=%0d, expected 0/1/127", hi, dir_a, lu); end
  endtask

  task automatic test_clr();
    bit ok;
    duty_a = -8'sd128;
    wait_upd_a(ok);
    n_chk++; if (!ok || sat_a !== 1'b1) begin n_fail++; $display("FAIL clr_pre: got ok=%0d sat=%b, expected 1/1", ok, sat_a); end
    repeat (10) @(negedge clk);
    clr_a = 1;
    @(negedge clk);
    clr_a = 0;
    n_chk++; if ({pwm_a, dir_a, upd_a, sat_a} !== 4'b0) begin n_fail++; $display("FAIL clr_state: got %b, expected 0000", {pwm_a, dir_a, upd_a, sat_a}); end
    @(negedge clk);
    n_chk++; if ({upd_a, dir_a, sat_a} !== 3'b111) begin n_fail++; $display("FAIL clr_restart: got upd,dir,sat=%b, expected 111", {upd_a, dir_a, sat_a}); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int first_upd, nupd, hi;
    duty_b = 8'sd64; en_b = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pwm_b) begin
        seen = 1;
        break;
      end
    end
    n_chk++; if (!seen) begin n_fail++; $display("FAIL rstmid_high_timeout: got pwm 0, expected 1"); end
    #2 rst_b = 0;
    #1;
    n_chk++; if ({pwm_b, upd_b} !== 2'b00) begin n_fail++; $display("FAIL rstmid_async: got %b, expected 00", {pwm_b, upd_b}); end
    @(negedge clk);
    rst_b = 1;
    @(negedge clk);
    n_chk++; if (upd_b !== 1'b1) begin n_fail++; $display("FAIL rstmid_first_upd: got %b, expected 1", upd_b); end
    first_upd = -1; nupd = 0; hi = 0;
    for (int k = 1; k <= 520; k++) begin
      @(negedge clk);
      if (upd_b) begin
        nupd++;
        if (first_upd < 0) first_upd = k;
      end
      if (pwm_b && first_upd < 0) hi++;
    end
    n_chk++; if (first_upd != 508 || nupd != 1) begin n_fail++; $display("FAIL presc4_period: got upd at %0d (n=%0d), expected 508 (n=1)", first_upd, nupd); end
    n_chk++; if (hi != 256) begin n_fail++; $display("FAIL presc4_highs: got %0d, expected 256", hi); end
  endtask

  initial begin
    test_reset();
    test_pos64();
    test_midchange();
    test_sat();
    test_reversal();
    test_en_drop();
    test_clr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
